pacman_dir_ctrl: RTL
====================

# pacman_dir_ctrl

Input controller between the four Basys3 direction push-buttons and the Pacman movement logic. Per button it synchronizes, debounces and edge-detects the raw input, producing a single-cycle press pulse. It arbitrates simultaneous presses round-robin and holds the winning direction as a pending request. The request is committed to the current heading on the next game-movement tick.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1_000_000: consecutive cycles a synchronized level must differ from the stable level before it is accepted (10 ms at 100 MHz); legal range ≥ 2.
- CNT_W, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- btn  input  4  raw, asynchronous buttons; bit 0 up, 1 down, 2 left, 3 right; active-high.
- game_tick  input  1  single-cycle pulse, one per movement step, from the frame timer.
- cur_dir  output  2  committed heading: 0 up, 1 down, 2 left, 3 right.
- moving  output  1  high once any direction has been committed.
- pending_valid  output  1  a direction request is waiting for game_tick.
- pending_dir  output  2  waiting direction; meaningful only when pending_valid.
- dir_changed  output  1  one-cycle pulse in the cycle after a commit.

## Operation
- Synchronizer: two flops per button (sync1, sync2), reset 0.
- Debouncer, per button: stable level (reset 0) and counter (reset 0).
  - When sync2 equals stable, the counter clears to 0.
  - When sync2 differs from stable and the counter is below DEBOUNCE_CYCLES-1, the counter increments.
  - When sync2 differs from stable and the counter equals DEBOUNCE_CYCLES-1, stable takes sync2 and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Edge detect, per button: registered press pulse equal to stable AND NOT stable_delayed, reset 0. Exactly one pulse per accepted press; release produces no pulse.
- Arbiter: a 2-bit round-robin pointer rr (reset 0) selects among the press pulses.
  - The search order is rr, rr+1, rr+2, rr+3, modulo 4. The first asserted pulse wins.
  - On a grant, rr becomes winner+1 (mod 4).
  - With no pulses, rr holds its value.
  - Losing simultaneous pulses are dropped, not queued.
- Pending register:
  - On a grant, pending_dir takes the winner and pending_valid is set. A newer grant overwrites an older pending request.
- Commit, on a game_tick cycle:
  - If a grant occurs in the same cycle, the grant is committed directly (bypass). pending_valid ends 0.
  - Else, if pending_valid is set, pending_dir is committed and pending_valid clears.
  - Else, nothing changes and dir_changed stays 0.
- Commit effects:
  - cur_dir takes the committed direction and moving is set.
  - dir_changed pulses if the committed direction differs from the old cur_dir, or if moving was 0 before the commit.
  - Re-committing the current heading while moving gives no pulse.
- Reversal (for example up to down) is legal with no restriction.

## Timing
- Reset values: cur_dir 0, moving 0, pending_valid 0, pending_dir 0, dir_changed 0, rr 0, all counters, synchronizers, stable levels and pulses 0. Assertion of reset mid-debounce or mid-request discards everything, asynchronously.
- Press latency, with btn high first sampled at edge k and held:
  - sync2 is high after edge k+1.
  - stable rises at edge k+DEBOUNCE_CYCLES+1.
  - The press pulse is high for the one cycle after edge k+DEBOUNCE_CYCLES+2.
  - pending_valid and pending_dir update at edge k+DEBOUNCE_CYCLES+3.
- Commit latency: game_tick high in a cycle means cur_dir, moving, dir_changed and the pending_valid clear all update at the following edge. dir_changed stays high for exactly one cycle.
- Bypass: press pulse and game_tick in the same cycle cause cur_dir to update at the next edge.
- game_tick is assumed to be a one-cycle pulse. If held high for several cycles, each high cycle is an independent commit opportunity.

## Test plan
(DEBOUNCE_CYCLES=4 throughout.)
- Reset, then btn=0001 held and game_tick pulsed once after pending_valid -> pending_valid=1 and pending_dir=0 at edge k+7; after the tick: cur_dir=0, moving=1, dir_changed high for 1 cycle, pending_valid=0.
- btn[3] high for 3 cycles, then low -> no press pulse, pending_valid stays 0.
- btn=0110 asserted in the same cycle with rr=0 -> grant down (1), rr=2. Repeat after release with rr=2 -> grant left (2), rr=3.
- Pending=right; a new press of up arrives before game_tick -> pending_dir=0. The tick commits up; right is never committed.
- Press pulse for left coincident with game_tick, pending_dir=down -> cur_dir=2 next edge, pending_valid=0, dir_changed=1.
- Reset asserted asynchronously while the debounce counter=2 and pending_valid=1 -> all outputs 0 immediately. After release, btn still held requires the full 4-cycle debounce again.

Source files
------------

// File: rtl/pacman_dir_ctrl.sv
// Debounces the four direction buttons, round-robin arbitrates press pulses and commits the pending heading on game_tick.
// Press-to-pending latency DEBOUNCE_CYCLES+3 edges, commit one edge after game_tick; no backpressure: losing or superseded presses are dropped.
module pacman_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       game_tick,
    output logic [1:0] cur_dir,
    output logic       moving,
    output logic       pending_valid,
    output logic [1:0] pending_dir,
    output logic       dir_changed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1, sync2, stable, stable_d, press;
    logic [CNT_W-1:0] cnt [4];
    logic [1:0]       rr;
    logic             grant;
    logic [1:0]       win;
    logic             commit_en;
    logic [1:0]       commit_dir;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // A level is accepted only after it has differed from stable for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_d <= '0;
            press    <= '0;
        end else begin
            stable_d <= stable;
            press    <= stable & ~stable_d;
        end
    end

    always_comb begin
        logic [1:0] idx;
        idx   = rr;
        grant = 1'b0;
        win   = rr;
        for (int i = 0; i < 4; i++) begin
            idx = rr + 2'(i);
            if (!grant && press[idx]) begin
                grant = 1'b1;
                win   = idx;
            end
        end
    end

    // A same-cycle grant bypasses the pending register when the tick arrives.
    assign commit_en  = game_tick & (grant | pending_valid);
    assign commit_dir = grant ? win : pending_dir;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr            <= '0;
            pending_valid <= 1'b0;
            pending_dir   <= '0;
            cur_dir       <= '0;
            moving        <= 1'b0;
            dir_changed   <= 1'b0;
        end else begin
            if (grant) begin
                rr            <= win + 2'd1;
                pending_dir   <= win;
                pending_valid <= 1'b1;
            end
            if (game_tick) pending_valid <= 1'b0;
            dir_changed <= commit_en && ((commit_dir != cur_dir) || !moving);
            if (commit_en) begin
                cur_dir <= commit_dir;
                moving  <= 1'b1;
            end
        end
    end

endmodule
